vga_timing_sequencer: RTL
=========================

VGA_TIMING_SEQUENCER -- requirements
Module: vga_timing_sequencer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48 (pixels); H_TOTAL = sum of the four H parameters = 800.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (lines); V_TOTAL = sum of the four V parameters = 525.
REQ-004 SHALL have port clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port pix_en, input, 1 bit, pixel-rate clock enable; advances counters by one pixel.
REQ-007 SHALL have port run, input, 1 bit, level request to generate frames.
REQ-008 SHALL have ports h_count and v_count, output, 10 bits each, current pixel and line position.
REQ-009 SHALL have ports hsync_n and vsync_n, output, 1 bit each, active-low sync pulses.
REQ-010 SHALL have port video_on, output, 1 bit, high inside the active area.
REQ-011 SHALL have ports line_start, frame_start and v_tick, output, 1 bit each, single-clk strobes.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN and DRAIN.
REQ-014 IDLE: counters SHALL be held at 0, hsync_n=1, vsync_n=1, video_on=0, and all strobes SHALL be 0.
REQ-015 IDLE -> RUN SHALL occur on the first clk with run=1; the first counting pix_en then presents pixel (0,0).
REQ-016 RUN -> DRAIN SHALL occur on any clk with run=0; counting continues unchanged.
REQ-017 DRAIN -> RUN SHALL occur on any clk with run=1, with no counter disturbance.
REQ-018 DRAIN -> IDLE SHALL occur on the pix_en cycle with h=H_TOTAL-1 and v=V_TOTAL-1; counters become 0 on that edge.
REQ-019 In RUN or DRAIN, a clk with pix_en=1 SHALL advance h_count by 1; at h=H_TOTAL-1, h_count wraps to 0 and v_count advances.
REQ-020 v_count SHALL wrap from V_TOTAL-1 to 0; both counters SHALL hold when pix_en=0.
REQ-021 v_tick SHALL equal pix_en AND (h_count=H_TOTAL-1) AND (state not IDLE), so it can drive a downstream line counter enable.
REQ-022 line_start SHALL equal pix_en AND h_count=0 AND (state not IDLE).
REQ-023 frame_start SHALL equal line_start AND v_count=0.
REQ-024 hsync_n SHALL be 0 exactly when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-025 vsync_n SHALL be 0 exactly when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-026 video_on SHALL be 1 exactly when h_count < H_ACTIVE and v_count < V_ACTIVE, and the state is not IDLE.
REQ-027 hsync_n, vsync_n and video_on SHALL be combinational decodes of the registered counters and state only, never of pix_en or run.
REQ-028 All count comparisons SHALL be unsigned; counters SHALL never exceed their TOTAL-1.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, h_count=0, v_count=0, hsync_n=1, vsync_n=1, video_on=0, all strobes 0 and busy=0, regardless of clk.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no drain.
REQ-031 After rst_n rises, the block SHALL stay in IDLE until run=1 is sampled.

Verification
REQ-032 Reset test: assert rst_n=0 mid-line at h=300 -> all outputs take their reset values without a clk edge.
REQ-033 Line timing test: run=1, pix_en=1 every clk -> hsync_n low for exactly 96 pix_en, from h=656; v_tick at h=799; line_start at h=0.
REQ-034 Frame timing test: run=1, pix_en=1 every clk -> vsync_n low on lines 490..491; frame_start every 420000 pix_en; v wraps 524 -> 0.
REQ-035 Enable test: pix_en=1 every other clk -> counters hold on pix_en=0 cycles, strobes never assert on those cycles, and the frame period is 840000 clk.
REQ-036 Drain test: drop run at (h=100, v=200) -> busy stays 1 until the (799,524) step, then IDLE with counters 0 and no further strobes.
REQ-037 Re-run test: drop run, then reassert it at v=300 before the frame ends -> no counter discontinuity and frame_start occurs at the normal wrap.

Source files
------------

// File: rtl/vga_timing_sequencer.sv
// ---------------------------------------------------------------------------
// vga_timing_sequencer
//
// Generates the VGA raster position and the sync, blanking and strobe signals
// derived from it. The counters advance one pixel per pix_en while the
// sequencer is running. When run is dropped, the current frame plays out to
// its last pixel (DRAIN) before the block goes idle. This guarantees that a
// downstream display never sees a truncated frame.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   pix_en       pixel-rate clock enable, one pixel step per asserted cycle
//   run          level request to generate frames
//   h_count      current pixel within the line   (0 .. H_TOTAL-1)
//   v_count      current line within the frame   (0 .. V_TOTAL-1)
//   hsync_n      active-low horizontal sync
//   vsync_n      active-low vertical sync
//   video_on     high while the position is inside the visible area
//   line_start   single-clk strobe on the pix_en step of pixel 0 of a line
//   frame_start  single-clk strobe on the pix_en step of pixel (0,0)
//   v_tick       single-clk strobe on the pix_en step of the last pixel of a
//                line; usable directly as a line-counter enable downstream
//   busy         high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module vga_timing_sequencer #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic       run,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start,
   output logic       v_tick,
   output logic       busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // All decode boundaries as 10-bit unsigned constants so every comparison
   // against the counters is unsigned and width-matched.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       active;
   logic       step;
   logic       at_h_last;
   logic       at_v_last;

   assign active    = (state != ST_IDLE);
   assign step      = active & pix_en;
   // ">=" rather than "==" so that a corrupted count can never run past the
   // end of the line or frame; it simply wraps on the next step.
   assign at_h_last = (h_count >= H_LAST);
   assign at_v_last = (v_count >= V_LAST);

   // Next-state and next-position logic.
   always_comb begin
      state_nxt = state;
      h_nxt     = h_count;
      v_nxt     = v_count;

      if (step) begin
         if (at_h_last) begin
            h_nxt = 10'd0;
            v_nxt = at_v_last ? 10'd0 : v_count + 10'd1;
         end else begin
            h_nxt = h_count + 10'd1;
         end
      end

      case (state)
         ST_IDLE: begin
            // Entering RUN does not itself count: the first pix_en in RUN
            // is the one that presents pixel (0,0).
            h_nxt = 10'd0;
            v_nxt = 10'd0;
            if (run) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!run) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // A renewed request wins over finishing the drain, so a request
            // arriving on the very last pixel keeps the raster going.
            if (run) begin
               state_nxt = ST_RUN;
            end else if (step && at_h_last && at_v_last) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            h_nxt     = 10'd0;
            v_nxt     = 10'd0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         h_count <= 10'd0;
         v_count <= 10'd0;
      end else begin
         state   <= state_nxt;
         h_count <= h_nxt;
         v_count <= v_nxt;
      end
   end

   // Raster decodes depend only on registered position and state, so they
   // are glitch-free with respect to pix_en and run.
   assign hsync_n  = ~(active && (h_count >= HS_START) && (h_count < HS_END));
   assign vsync_n  = ~(active && (v_count >= VS_START) && (v_count < VS_END));
   assign video_on = active && (h_count < H_VIS) && (v_count < V_VIS);

   // Strobes are qualified by pix_en so each fires on exactly one clk per
   // pixel step, even when pix_en is slower than clk.
   assign line_start  = step && (h_count == 10'd0);
   assign frame_start = line_start && (v_count == 10'd0);
   assign v_tick      = step && (h_count == H_LAST);
   assign busy        = active;

endmodule
